rsa_exp_ctrl: RTL and testbench

RSA_EXP_CTRL -- requirements
Module: rsa_exp_ctrl

---
 rtl/rsa_pkg.sv | 35 +++
 rtl/rsa_exp_ctrl.sv | 160 ++++++++++++++++
 tb/tb_rsa_exp_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared encodings for the RSA exponentiation controller and its operand muxes.
// Holds the operand-select codes, the sequencer state enum and small state helpers.
// Pure declarations: no logic, no latency, no flow control.
package rsa_pkg;

   // Operand-mux select codes, shared with the datapath mux instances
   typedef enum logic [1:0] {
      SEL_ONE  = 2'b00,
      SEL_ACC  = 2'b01,
      SEL_BASE = 2'b10,
      SEL_ZERO = 2'b11
   } sel_t;

   // Sequencer states: one ISSUE/WAIT pair per multiplier operation kind
   typedef enum logic [3:0] {
      ST_IDLE,
      ST_INIT,
      ST_SQR_ISSUE,
      ST_SQR_WAIT,
      ST_MUL_ISSUE,
      ST_MUL_WAIT,
      ST_POST_ISSUE,
      ST_POST_WAIT,
      ST_DONE
   } state_t;

   function automatic logic is_issue(input state_t s);
      return (s == ST_SQR_ISSUE) || (s == ST_MUL_ISSUE) || (s == ST_POST_ISSUE);
   endfunction

   function automatic logic is_wait(input state_t s);
      return (s == ST_SQR_WAIT) || (s == ST_MUL_WAIT) || (s == ST_POST_WAIT);
   endfunction

endpackage

// File: rtl/rsa_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external Montgomery multiplier.
// Latency: start to done = 2 + ops*(mult latency + 2) cycles, ops = WIDTH + popcount(exp) + 1.
// Backpressure: start ignored while busy; each op stalls in WAIT until mmm_done is seen.
module rsa_exp_ctrl
   import rsa_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] exponent,
   input  logic             mmm_done,
   output logic [1:0]       sel_x,
   output logic [1:0]       sel_y,
   output logic             mmm_start,
   output logic             acc_init,
   output logic             acc_we,
   output logic             busy,
   output logic             done
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   state_t           state_q;
   state_t           state_nxt;
   logic [WIDTH-1:0] exp_q;
   logic [CW-1:0]    cnt_q;
   logic             cap;
   logic             shift;

   sel_t             sel_x_d;
   sel_t             sel_y_d;
   logic             mmm_start_d;
   logic             acc_init_d;
   logic             acc_we_d;
   logic             busy_d;
   logic             done_d;

   // State register; async reset drops straight to IDLE mid-operation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Next-state: a WAIT state is left only in the cycle acc_we is high, so the
   // selects stay put while the multiplier result is being written into ACC
   always_comb begin
      state_nxt = state_q;
      cap       = 1'b0;
      shift     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_INIT;
               cap       = 1'b1;
            end
         end
         ST_INIT:       state_nxt = ST_SQR_ISSUE;
         ST_SQR_ISSUE:  state_nxt = ST_SQR_WAIT;
         ST_SQR_WAIT: begin
            if (acc_we) begin
               if (exp_q[WIDTH-1]) begin
                  state_nxt = ST_MUL_ISSUE;
               end else if (cnt_q == '0) begin
                  state_nxt = ST_POST_ISSUE;
               end else begin
                  state_nxt = ST_SQR_ISSUE;
                  shift     = 1'b1;
               end
            end
         end
         ST_MUL_ISSUE:  state_nxt = ST_MUL_WAIT;
         ST_MUL_WAIT: begin
            if (acc_we) begin
               if (cnt_q == '0) begin
                  state_nxt = ST_POST_ISSUE;
               end else begin
                  state_nxt = ST_SQR_ISSUE;
                  shift     = 1'b1;
               end
            end
         end
         ST_POST_ISSUE: state_nxt = ST_POST_WAIT;
         ST_POST_WAIT: begin
            if (acc_we) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE:       state_nxt = ST_IDLE;
         default:       state_nxt = ST_IDLE;
      endcase
   end

   // Output decode from the upcoming state so every output comes from a flop
   always_comb begin
      sel_x_d = SEL_ZERO;
      sel_y_d = SEL_ZERO;
      case (state_nxt)
         ST_SQR_ISSUE, ST_SQR_WAIT: begin
            sel_x_d = SEL_ACC;
            sel_y_d = SEL_ACC;
         end
         ST_MUL_ISSUE, ST_MUL_WAIT: begin
            sel_x_d = SEL_ACC;
            sel_y_d = SEL_BASE;
         end
         ST_POST_ISSUE, ST_POST_WAIT: begin
            sel_x_d = SEL_ACC;
            sel_y_d = SEL_ONE;
         end
         default: ;
      endcase
      mmm_start_d = is_issue(state_nxt);
      acc_init_d  = (state_nxt == ST_INIT);
      // one write per op: a second mmm_done while the write is pending is dropped
      acc_we_d    = is_wait(state_q) && mmm_done && !acc_we;
      busy_d      = (state_nxt != ST_IDLE);
      done_d      = (state_nxt == ST_DONE);
   end

   // Registered outputs; acc_we doubles as the "result pending" flag of WAIT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_x     <= SEL_ZERO;
         sel_y     <= SEL_ZERO;
         mmm_start <= 1'b0;
         acc_init  <= 1'b0;
         acc_we    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         sel_x     <= sel_x_d;
         sel_y     <= sel_y_d;
         mmm_start <= mmm_start_d;
         acc_init  <= acc_init_d;
         acc_we    <= acc_we_d;
         busy      <= busy_d;
         done      <= done_d;
      end
   end

   // Exponent shift register and bit counter: MSB is always the bit being processed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q <= '0;
         cnt_q <= '0;
      end else if (cap) begin
         exp_q <= exponent;
         cnt_q <= CW'(WIDTH - 1);
      end else if (shift) begin
         exp_q <= {exp_q[WIDTH-2:0], 1'b0};
         cnt_q <= cnt_q - CW'(1);
      end
   end

endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// Bench for rsa_exp_ctrl: mock Montgomery multiplier with an ACC model modulo 197.
// Directed sequences, robustness against stray start/mmm_done, mid-run reset, random modexp.
// Multiplier latency is programmable per run.
module tb_rsa_exp_ctrl;

   localparam int W     = 8;
   localparam int N_MOD = 197;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] exponent;
   logic         mmm_done = 1'b0;
   logic [1:0]   sel_x;
   logic [1:0]   sel_y;
   logic         mmm_start;
   logic         acc_init;
   logic         acc_we;
   logic         busy;
   logic         done;

   int total = 0;
   int bad   = 0;

   rsa_exp_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .exponent  (exponent),
      .mmm_done  (mmm_done),
      .sel_x     (sel_x),
      .sel_y     (sel_y),
      .mmm_start (mmm_start),
      .acc_init  (acc_init),
      .acc_we    (acc_we),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // knobs driven by the test tasks
   int lat_v      = 1;
   int base_m     = 1;
   int rinv       = 0;
   int r_mod      = 256 % N_MOD;
   bit mon_clr    = 1'b0;
   bit spur_done  = 1'b0;
   bit spur_issue = 1'b0;

   // mock multiplier / ACC model / monitor state
   int    rem = 0, res = 0, acc = 0;
   int    n_start = 0, n_sqr = 0, n_mul = 0, n_post = 0, n_we = 0;
   int    n_init = 0, n_done = 0, n_busy = 0, sel_bad = 0;
   int    cyc = 0, last_we_cyc = 0, gap = 0;
   string seq_s = "";
   logic [1:0] fx, fy;
   bit    inflight = 1'b0;

   function automatic int opnd(input logic [1:0] s);
      case (s)
         2'b00:   return 1;
         2'b01:   return acc;
         2'b10:   return base_m;
         default: return 0;
      endcase
   endfunction

   // plain right-to-left modexp, independent of the Montgomery path
   function automatic int ref_pow(input int b, input int e, input int n);
      int r  = 1;
      int bb = b % n;
      for (int i = 0; i < 8; i++) begin
         if (e[i]) r = (r * bb) % n;
         bb = (bb * bb) % n;
      end
      return r;
   endfunction

   // Multiplier model + ACC register model + event counters, all on the falling edge
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         rem      = 0;
         mmm_done = 1'b0;
         inflight = 1'b0;
      end else begin
         mmm_done = 1'b0;
         if (rem > 0) begin
            rem--;
            if (rem == 0) mmm_done = 1'b1;
         end
         if (mon_clr) begin
            n_start = 0; n_sqr = 0; n_mul = 0; n_post = 0; n_we = 0;
            n_init = 0; n_done = 0; n_busy = 0; sel_bad = 0; gap = 0;
            seq_s = "";
         end
         if (inflight && ((sel_x !== fx) || (sel_y !== fy))) sel_bad++;
         if (mmm_start) begin
            n_start++;
            fx       = sel_x;
            fy       = sel_y;
            inflight = 1'b1;
            res      = (((opnd(sel_x) * opnd(sel_y)) % N_MOD) * rinv) % N_MOD;
            rem      = lat_v;
            if (sel_x == 2'b01 && sel_y == 2'b01) begin
               n_sqr++; seq_s = {seq_s, "S"};
            end else if (sel_x == 2'b01 && sel_y == 2'b10) begin
               n_mul++; seq_s = {seq_s, "M"};
            end else if (sel_x == 2'b01 && sel_y == 2'b00) begin
               n_post++; seq_s = {seq_s, "P"};
            end else begin
               seq_s = {seq_s, "X"};
            end
            if (spur_issue) mmm_done = 1'b1;
         end
         if (spur_done) mmm_done = 1'b1;
         if (acc_init) begin
            n_init++;
            acc = r_mod;
         end
         if (acc_we) begin
            n_we++;
            acc         = res;
            inflight    = 1'b0;
            last_we_cyc = cyc;
         end
         if (busy) n_busy++;
         if (done) begin
            n_done++;
            gap = cyc - last_we_cyc;
         end
      end
   end

   // Launch one exponentiation and wait for done (bounded); optionally disturb it
   task automatic run_op(input logic [7:0] e, input int b, input int l,
                         input bit disturb, output bit tmo);
      @(negedge clk);
      lat_v   = l;
      base_m  = (b * r_mod) % N_MOD;
      mon_clr = 1'b1;
      @(negedge clk);
      #1;
      mon_clr  = 1'b0;
      start    = 1'b1;
      exponent = e;
      @(negedge clk);
      #1;
      start = 1'b0;
      if (disturb) begin
         exponent   = ~e;
         spur_issue = 1'b1;
         repeat (6) @(negedge clk);
         #1;
         start    = 1'b1;
         exponent = 8'h5A;
         @(negedge clk);
         #1;
         start    = 1'b0;
         exponent = 8'hFF;
      end
      tmo = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         #1;
         if (n_done != 0) begin
            tmo = 1'b0;
            break;
         end
      end
      spur_issue = 1'b0;
      repeat (3) @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      start    = 1'b0;
      exponent = '0;
      repeat (3) @(negedge clk);
      #1;
      total++;
      if ({sel_x, sel_y} !== 4'b1111) begin
         bad++; $display("FAIL reset_sel got=%b want=1111", {sel_x, sel_y});
      end
      total++;
      if ({mmm_start, acc_init, acc_we, busy, done} !== 5'b00000) begin
         bad++; $display("FAIL reset_pulses got=%b want=00000",
                         {mmm_start, acc_init, acc_we, busy, done});
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_exp_81();
      bit tmo;
      run_op(8'h81, 3, 3, 1'b0, tmo);
      total++;
      if (tmo) begin bad++; $display("FAIL e81_timeout got=none want=done"); end
      total++;
      if (seq_s != "SMSSSSSSSMP") begin
         bad++; $display("FAIL e81_seq got=%s want=SMSSSSSSSMP", seq_s);
      end
      total++;
      if (n_start != 11) begin bad++; $display("FAIL e81_starts got=%0d want=11", n_start); end
      total++;
      if (n_done != 1) begin bad++; $display("FAIL e81_done got=%0d want=1", n_done); end
      total++;
      if (n_init != 1 || n_we != 11) begin
         bad++; $display("FAIL e81_init_we got=%0d/%0d want=1/11", n_init, n_we);
      end
      total++;
      if (n_busy != 57) begin bad++; $display("FAIL e81_busy got=%0d want=57", n_busy); end
      total++;
      if (sel_bad != 0) begin bad++; $display("FAIL e81_sel_stable got=%0d want=0", sel_bad); end
      total++;
      if (acc != ref_pow(3, 8'h81, N_MOD)) begin
         bad++; $display("FAIL e81_acc got=%0d want=%0d", acc, ref_pow(3, 8'h81, N_MOD));
      end
      total++;
      if ({sel_x, sel_y, busy} !== 5'b11110) begin
         bad++; $display("FAIL e81_idle got=%b want=11110", {sel_x, sel_y, busy});
      end
   endtask

   task automatic test_exp_00();
      bit tmo;
      run_op(8'h00, 5, 2, 1'b0, tmo);
      total++;
      if (tmo) begin bad++; $display("FAIL e00_timeout got=none want=done"); end
      total++;
      if (seq_s != "SSSSSSSSP") begin
         bad++; $display("FAIL e00_seq got=%s want=SSSSSSSSP", seq_s);
      end
      total++;
      if (n_mul != 0 || n_post != 1) begin
         bad++; $display("FAIL e00_mul_post got=%0d/%0d want=0/1", n_mul, n_post);
      end
      total++;
      if (gap != 1) begin bad++; $display("FAIL e00_we_to_done got=%0d want=1", gap); end
      total++;
      if (n_busy != 38) begin bad++; $display("FAIL e00_busy got=%0d want=38", n_busy); end
      total++;
      if (acc != 1) begin bad++; $display("FAIL e00_acc got=%0d want=1", acc); end
   endtask

   task automatic test_exp_ff();
      bit tmo;
      run_op(8'hFF, 2, 1, 1'b0, tmo);
      total++;
      if (tmo) begin bad++; $display("FAIL eff_timeout got=none want=done"); end
      total++;
      if (seq_s != "SMSMSMSMSMSMSMSMP") begin
         bad++; $display("FAIL eff_seq got=%s want=SMSMSMSMSMSMSMSMP", seq_s);
      end
      total++;
      if (n_start != 17) begin bad++; $display("FAIL eff_starts got=%0d want=17", n_start); end
      total++;
      if (n_busy != 53) begin bad++; $display("FAIL eff_busy got=%0d want=53", n_busy); end
      total++;
      if (acc != ref_pow(2, 8'hFF, N_MOD)) begin
         bad++; $display("FAIL eff_acc got=%0d want=%0d", acc, ref_pow(2, 8'hFF, N_MOD));
      end
   endtask

   task automatic test_ignore();
      bit tmo;
      run_op(8'h81, 7, 3, 1'b1, tmo);
      total++;
      if (tmo) begin bad++; $display("FAIL ign_timeout got=none want=done"); end
      total++;
      if (seq_s != "SMSSSSSSSMP") begin
         bad++; $display("FAIL ign_seq got=%s want=SMSSSSSSSMP", seq_s);
      end
      total++;
      if (n_we != 11 || n_done != 1) begin
         bad++; $display("FAIL ign_we_done got=%0d/%0d want=11/1", n_we, n_done);
      end
      total++;
      if (n_busy != 57) begin bad++; $display("FAIL ign_busy got=%0d want=57", n_busy); end
      total++;
      if (acc != ref_pow(7, 8'h81, N_MOD)) begin
         bad++; $display("FAIL ign_acc got=%0d want=%0d", acc, ref_pow(7, 8'h81, N_MOD));
      end
      // stray mmm_done while idle
      @(negedge clk);
      mon_clr = 1'b1;
      @(negedge clk);
      #1;
      mon_clr   = 1'b0;
      spur_done = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      spur_done = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      total++;
      if (n_we != 0 || n_start != 0 || busy !== 1'b0) begin
         bad++; $display("FAIL ign_idle_done got=we%0d/st%0d/busy%b want=0/0/0",
                         n_we, n_start, busy);
      end
   endtask

   task automatic test_reset_mid();
      bit tmo;
      bit found = 1'b0;
      @(negedge clk);
      lat_v   = 3;
      base_m  = (3 * r_mod) % N_MOD;
      mon_clr = 1'b1;
      @(negedge clk);
      #1;
      mon_clr  = 1'b0;
      start    = 1'b1;
      exponent = 8'h81;
      @(negedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         #1;
         if (mmm_start && sel_y == 2'b10) begin
            found = 1'b1;
            break;
         end
      end
      total++;
      if (!found) begin bad++; $display("FAIL rmid_find_mul got=none want=MUL_ISSUE"); end
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      total++;
      if ({sel_x, sel_y, mmm_start, acc_init, acc_we, busy, done} !== 9'b1111_00000) begin
         bad++; $display("FAIL rmid_async got=%b want=111100000",
                         {sel_x, sel_y, mmm_start, acc_init, acc_we, busy, done});
      end
      @(posedge clk);
      #1;
      total++;
      if ({sel_x, sel_y, busy, done} !== 6'b111100) begin
         bad++; $display("FAIL rmid_idle got=%b want=111100", {sel_x, sel_y, busy, done});
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      total++;
      if (n_done != 0) begin bad++; $display("FAIL rmid_no_done got=%0d want=0", n_done); end
      run_op(8'h81, 3, 3, 1'b0, tmo);
      total++;
      if (tmo || seq_s != "SMSSSSSSSMP") begin
         bad++; $display("FAIL rmid_rerun got=%s tmo=%0d want=SMSSSSSSSMP", seq_s, tmo);
      end
      total++;
      if (acc != ref_pow(3, 8'h81, N_MOD)) begin
         bad++; $display("FAIL rmid_acc got=%0d want=%0d", acc, ref_pow(3, 8'h81, N_MOD));
      end
   endtask

   task automatic test_random();
      bit         tmo;
      logic [7:0] e;
      int         b;
      int         l;
      for (int k = 0; k < 200; k++) begin
         e = 8'($urandom_range(0, 255));
         b = int'($urandom_range(2, 196));
         l = int'($urandom_range(1, 4));
         run_op(e, b, l, 1'b0, tmo);
         total++;
         if (tmo) begin bad++; $display("FAIL rnd_timeout e=%h got=none want=done", e); end
         total++;
         if (n_start != 9 + $countones(e)) begin
            bad++; $display("FAIL rnd_ops e=%h got=%0d want=%0d", e, n_start, 9 + $countones(e));
         end
         total++;
         if (acc != ref_pow(b, int'(e), N_MOD)) begin
            bad++; $display("FAIL rnd_acc b=%0d e=%h got=%0d want=%0d",
                            b, e, acc, ref_pow(b, int'(e), N_MOD));
         end
      end
   endtask

   initial begin
      for (int k = 1; k < N_MOD; k++) begin
         if ((r_mod * k) % N_MOD == 1) rinv = k;
      end
      test_reset();
      test_exp_81();
      test_exp_00();
      test_exp_ff();
      test_ignore();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
